// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Frequency-sweep (chirp) controller that produces the phase increment p1
// for the sine/cosine NCO. It steps p1 from f_start towards f_stop in
// steps of f_step and holds each value for dwell+1 cycles. Single,
// sawtooth and triangle sweeps are supported, with abort and status pulses.
//
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous, active-high
//   start    start request, sampled only while idle
//   abort    return to idle immediately (beats start)
//   mode     0 single up, 1 sawtooth, 2 triangle, 3 same as 0
//   f_start  first increment
//   f_stop   last increment (effective stop is max(f_start, f_stop))
//   f_step   step size (0 behaves as 1)
//   dwell    each value is held dwell+1 cycles
//   p1       registered phase increment to the NCO
//   busy     high while a sweep runs
//   done     one-cycle pulse at the natural end of a single sweep
//   wrap     one-cycle pulse whenever a repeating sweep starts a new period
//
// state | meaning
// IDLE  | no sweep, p1 = 0, waiting for start
// UP    | ascending from f_start towards the effective stop
// DOWN  | descending back towards f_start (triangle mode only)

module nco_sweep_ctrl #(
  parameter int INC_W   = 13,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [INC_W-1:0]   f_start,
  input  logic [INC_W-1:0]   f_stop,
  input  logic [INC_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [INC_W-1:0]   p1,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic [INC_W-1:0]   fs_q;
  logic [INC_W-1:0]   stop_q;
  logic [INC_W-1:0]   step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;

  logic [INC_W:0]     up_sum;
  logic [INC_W:0]     bot_sum;
  logic [INC_W-1:0]   up_next;
  logic [INC_W-1:0]   down_next;
  logic [INC_W-1:0]   turn_up;
  logic [INC_W-1:0]   turn_down;
  logic               dwell_end;

  // Next-value arithmetic. Sums carry one extra bit so a step near full
  // scale clamps to the stop value instead of wrapping. Differences are
  // compared against the step before subtracting so nothing underflows
  // below f_start (stop_q >= fs_q and p1 >= fs_q always hold while busy).
  always_comb begin
    up_sum    = {1'b0, p1} + {1'b0, step_q};
    up_next   = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[INC_W-1:0];
    bot_sum   = {1'b0, fs_q} + {1'b0, step_q};
    turn_up   = (bot_sum > {1'b0, stop_q}) ? stop_q : bot_sum[INC_W-1:0];
    turn_down = ((stop_q - fs_q) > step_q) ? (stop_q - step_q) : fs_q;
    down_next = ((p1 - fs_q) > step_q) ? (p1 - step_q) : fs_q;
    dwell_end = (cnt == dwell_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      mode_q  <= 2'd0;
      fs_q    <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt     <= '0;
      p1      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (abort) begin
        state <= IDLE;
        cnt   <= '0;
        p1    <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mode_q  <= mode;
              fs_q    <= f_start;
              stop_q  <= (f_stop > f_start) ? f_stop : f_start;
              step_q  <= (f_step == '0) ? INC_W'(1) : f_step;
              dwell_q <= dwell;
              cnt     <= '0;
              p1      <= f_start;
              busy    <= 1'b1;
              state   <= UP;
            end
          end

          UP: begin
            if (!dwell_end) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (p1 < stop_q) begin
                p1 <= up_next;
              end else begin
                case (mode_q)
                  2'd1: begin
                    p1   <= fs_q;
                    wrap <= 1'b1;
                  end
                  2'd2: begin
                    p1    <= turn_down;
                    state <= DOWN;
                  end
                  default: begin
                    p1    <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                  end
                endcase
              end
            end
          end

          DOWN: begin
            if (!dwell_end) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (p1 > fs_q) begin
                p1 <= down_next;
              end else begin
                // Bottom endpoint already held once; resume climbing.
                p1    <= turn_up;
                wrap  <= 1'b1;
                state <= UP;
              end
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            p1    <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
